multiplier_iter_pp: RTL and testbench
=====================================

Name: multiplier_iter_pp

Overview:
- Parametrised, iterative (shift-add) multiplier; successor to the single-cycle 32-bit registered multiplier.
- Trades latency for area: processes BPC multiplier bits per cycle under a start/valid handshake.
- Adds signed/unsigned mode, stall, and abort.
- Sits in datapaths where one product per several cycles suffices and a full-array multiplier is too large.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH.
- BPC, 1, multiplier bits consumed per CALC cycle; must divide WIDTH exactly (elaboration-time check).

Ports:
- iClk  in  1  clock, rising edge.
- iRst  in  1  asynchronous, active-high reset.
- iEn  in  1  advance enable; low freezes CALC.
- iClr  in  1  synchronous abort/clear.
- iStart  in  1  start request; sampled only in IDLE.
- iSigned  in  1  1 = two's-complement operands, 0 = unsigned; sampled with iStart.
- iData0  in  WIDTH  multiplicand; sampled with iStart.
- iData1  in  WIDTH  multiplier; sampled with iStart.
- oBusy  out  1  high in CALC and DONE.
- oValid  out  1  one-cycle result strobe.
- oData  out  2*WIDTH  product, held until next result or clear.

Behaviour:
- Reset: iRst high asynchronously forces state=IDLE; oData=0, oValid=0, oBusy=0, internal counter/accumulator=0. Mid-operation reset discards the operation.
- Priority on each edge: iRst > iClr > iEn/FSM.
- iClr high (any state): next state IDLE, oData=0, oValid=0, counter=0; iStart in the same cycle is ignored.
- States:
  - IDLE: if iStart, latch |iData0|, |iData1| (absolute value when iSigned, raw otherwise), result sign = iSigned & (msb0 ^ msb1), clear accumulator, counter=0, go to CALC. Otherwise stay.
  - CALC: when iEn=1, add multiplicand·(next BPC multiplier bits) shifted into the 2*WIDTH accumulator, counter+1. After N=WIDTH/BPC enabled cycles, go to DONE. When iEn=0, hold all state.
  - DONE: write oData = sign ? −acc : acc (mod 2^(2*WIDTH)); oValid=1 for exactly this cycle; next state IDLE unconditionally, independent of iEn.
- Latency: iStart sampled at edge E0 with iEn held high → oValid high after edge E0+N+1, low after E0+N+2. Each iEn-low cycle in CALC adds one cycle. iEn has no effect in IDLE or DONE.
- Throughput: one result per N+2 cycles. iStart while oBusy=1 is ignored; it is not queued.
- Arithmetic: magnitudes held in WIDTH-bit unsigned, so the most negative operand (−2^(WIDTH−1)) is exact. Product is exact in 2*WIDTH bits for both modes. No overflow case exists.
- oData changes only in DONE, on clear, or on reset. oValid is 0 outside DONE.

Optional Feature:
- Macro MULTIPLIER_ITER_PP_ACC_EN.
- Defined: adds port iAcc (in, 1), sampled with iStart. When iAcc=1, DONE writes oData = oData_prev + signed/unsigned product, mod 2^(2*WIDTH) (MAC). iClr/reset zero the running total.
- Undefined: port absent; DONE always writes the product only.

Test Plan:
- Unsigned basic, WIDTH=32, BPC=1, iEn=1: iData0=3, iData1=5, iSigned=0 → oValid exactly at start+33 edges; oData=0x000000000000000F; oBusy low the following cycle.
- Signed and extremes: −3×5 signed → 0xFFFFFFFFFFFFFFF1; 0xFFFFFFFF×0xFFFFFFFF unsigned → 0xFFFFFFFE00000001; 0x80000000×0x80000000 signed → 0x4000000000000000.
- Stall and ignored start: deassert iEn for 4 cycles mid-CALC, pulse iStart while busy → oValid delayed by exactly 4 cycles; result unchanged; no second operation starts.
- Clear/reset mid-op: iClr at cycle 10 of CALC → IDLE, oData=0, no oValid. Repeat with an async iRst pulse between edges → outputs 0 immediately.
- BPC=4 variant: 7×9 → oValid after start+9 edges; oData=63. Back-to-back starts (next iStart in the first IDLE cycle) → 10-cycle result spacing.
- MULTIPLIER_ITER_PP_ACC_EN: 2×3 with iAcc=0, then 4×5 with iAcc=1 → oData=6 then 26; iClr → 0.

Source files
------------

// File: rtl/multiplier_iter_pp_if.sv
// rtl/multiplier_iter_pp_if.sv - operand/result bus of multiplier_iter_pp
// iAcc exists only when MULTIPLIER_ITER_PP_ACC_EN is defined.
interface multiplier_iter_pp_if #(parameter int WIDTH = 32);
  logic               iStart;
  logic               iSigned;
  logic [WIDTH-1:0]   iData0;
  logic [WIDTH-1:0]   iData1;
`ifdef MULTIPLIER_ITER_PP_ACC_EN
  logic               iAcc;
`endif
  logic               oBusy;
  logic               oValid;
  logic [2*WIDTH-1:0] oData;

`ifdef MULTIPLIER_ITER_PP_ACC_EN
  modport master (output iStart, iSigned, iData0, iData1, iAcc,
                  input  oBusy, oValid, oData);
  modport slave  (input  iStart, iSigned, iData0, iData1, iAcc,
                  output oBusy, oValid, oData);
`else
  modport master (output iStart, iSigned, iData0, iData1,
                  input  oBusy, oValid, oData);
  modport slave  (input  iStart, iSigned, iData0, iData1,
                  output oBusy, oValid, oData);
`endif
endinterface

// File: rtl/multiplier_iter_pp.sv
// rtl/multiplier_iter_pp.sv - iterative shift-add multiplier, BPC bits per cycle, signed/unsigned
// Optional multiply-accumulate into oData when MULTIPLIER_ITER_PP_ACC_EN is defined.
module multiplier_iter_pp #(
  parameter int WIDTH = 32,
  parameter int BPC   = 1
) (
  input  logic iClk,
  input  logic iRst,
  input  logic iEn,
  input  logic iClr,
  multiplier_iter_pp_if.slave bus
);
  localparam int N  = WIDTH / BPC;
  localparam int CW = $clog2(N + 1);

  generate
    if (BPC < 1 || (WIDTH % BPC) != 0) begin : gBadBpc
      $error("multiplier_iter_pp: BPC must divide WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, stateNext;

  logic [2*WIDTH-1:0] mcand, acc, partial, product, result, dataQ;
  logic [WIDTH-1:0]   mplier, mag0, mag1;
  logic [CW-1:0]      cnt;
  logic               sign, validQ;
`ifdef MULTIPLIER_ITER_PP_ACC_EN
  logic               accMode;
`endif

  // Operands are held as magnitudes so the most negative value stays exact.
  assign mag0 = (bus.iSigned && bus.iData0[WIDTH-1]) ? -bus.iData0 : bus.iData0;
  assign mag1 = (bus.iSigned && bus.iData1[WIDTH-1]) ? -bus.iData1 : bus.iData1;

  assign partial = mcand * {{(2*WIDTH-BPC){1'b0}}, mplier[BPC-1:0]};
  assign product = sign ? -acc : acc;
`ifdef MULTIPLIER_ITER_PP_ACC_EN
  assign result  = accMode ? dataQ + product : product;
`else
  assign result  = product;
`endif

  assign bus.oBusy  = (state != IDLE);
  assign bus.oValid = validQ;
  assign bus.oData  = dataQ;

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) state <= IDLE;
    else      state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    if (iClr) begin
      stateNext = IDLE;
    end else begin
      case (state)
        IDLE:    if (bus.iStart) stateNext = CALC;
        CALC:    if (iEn && cnt == CW'(N - 1)) stateNext = DONE;
        DONE:    stateNext = IDLE;
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      sign    <= 1'b0;
      dataQ   <= '0;
      validQ  <= 1'b0;
`ifdef MULTIPLIER_ITER_PP_ACC_EN
      accMode <= 1'b0;
`endif
    end else if (iClr) begin
      acc    <= '0;
      cnt    <= '0;
      dataQ  <= '0;
      validQ <= 1'b0;
    end else begin
      validQ <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.iStart) begin
            mcand   <= {{WIDTH{1'b0}}, mag0};
            mplier  <= mag1;
            sign    <= bus.iSigned & (bus.iData0[WIDTH-1] ^ bus.iData1[WIDTH-1]);
            acc     <= '0;
            cnt     <= '0;
`ifdef MULTIPLIER_ITER_PP_ACC_EN
            accMode <= bus.iAcc;
`endif
          end
        end
        CALC: begin
          if (iEn) begin
            acc    <= acc + partial;
            mcand  <= mcand << BPC;
            mplier <= mplier >> BPC;
            cnt    <= cnt + 1'b1;
          end
        end
        DONE: begin
          dataQ  <= result;
          validQ <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_multiplier_iter_pp.sv
// tb/tb_multiplier_iter_pp.sv - self-checking bench for multiplier_iter_pp (BPC=1 and BPC=4 instances)
module tb_multiplier_iter_pp;
  logic iClk = 1'b0;
  logic iRst, iEn, iClr;
  int nCmp = 0;
  int nFail = 0;

  always #5 iClk = ~iClk;

  multiplier_iter_pp_if #(.WIDTH(32)) bus ();
  multiplier_iter_pp_if #(.WIDTH(32)) bus4 ();

  multiplier_iter_pp #(.WIDTH(32), .BPC(1)) dut (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr), .bus(bus));
  multiplier_iter_pp #(.WIDTH(32), .BPC(4)) dut4 (
    .iClk(iClk), .iRst(iRst), .iEn(iEn), .iClr(iClr), .bus(bus4));

  function automatic logic [63:0] refMul(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic [63:0] ea, eb;
    ea = s ? {{32{a[31]}}, a} : {32'd0, a};
    eb = s ? {{32{b[31]}}, b} : {32'd0, b};
    return ea * eb;
  endfunction

  function automatic logic getValid(input int sel);
    return (sel != 0) ? bus4.oValid : bus.oValid;
  endfunction

  function automatic logic [63:0] getData(input int sel);
    return (sel != 0) ? bus4.oData : bus.oData;
  endfunction

  // Called right after a negedge; leaves the bench at the negedge after the start edge.
  task automatic startOp(input int sel, input logic [31:0] a, input logic [31:0] b, input logic s);
    if (sel != 0) begin
      bus4.iData0 = a; bus4.iData1 = b; bus4.iSigned = s; bus4.iStart = 1'b1;
    end else begin
      bus.iData0 = a; bus.iData1 = b; bus.iSigned = s; bus.iStart = 1'b1;
    end
    @(posedge iClk);
    @(negedge iClk);
    bus.iStart = 1'b0;
    bus4.iStart = 1'b0;
  endtask

  task automatic waitValid(input int sel, output int lat);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge iClk);
      lat++;
      @(negedge iClk);
      if (getValid(sel)) return;
    end
    lat = -1;
  endtask

  task automatic watch(input int sel, input int cycles, output int nValid, output int nBusy);
    nValid = 0;
    nBusy = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge iClk);
      @(negedge iClk);
      if (getValid(sel)) nValid++;
      if (((sel != 0) ? bus4.oBusy : bus.oBusy) !== 1'b0) nBusy++;
    end
  endtask

  task automatic test_reset;
    iRst = 1'b1; iEn = 1'b1; iClr = 1'b0;
    bus.iStart = 0; bus.iSigned = 0; bus.iData0 = 0; bus.iData1 = 0;
    bus4.iStart = 0; bus4.iSigned = 0; bus4.iData0 = 0; bus4.iData1 = 0;
`ifdef MULTIPLIER_ITER_PP_ACC_EN
    bus.iAcc = 0; bus4.iAcc = 0;
`endif
    repeat (3) @(negedge iClk);
    nCmp++; if (bus.oData !== 64'd0) begin nFail++; $display("FAIL reset_data: got %h expected 0", bus.oData); end
    nCmp++; if (bus.oValid !== 1'b0) begin nFail++; $display("FAIL reset_valid: got %b expected 0", bus.oValid); end
    nCmp++; if (bus.oBusy !== 1'b0) begin nFail++; $display("FAIL reset_busy: got %b expected 0", bus.oBusy); end
    nCmp++; if (bus4.oData !== 64'd0) begin nFail++; $display("FAIL reset_data4: got %h expected 0", bus4.oData); end
    iRst = 1'b0;
    @(negedge iClk);
  endtask

  task automatic test_basic;
    int lat;
    startOp(0, 32'd3, 32'd5, 1'b0);
    nCmp++; if (bus.oBusy !== 1'b1) begin nFail++; $display("FAIL basic_busy: got %b expected 1", bus.oBusy); end
    waitValid(0, lat);
    nCmp++; if (lat !== 33) begin nFail++; $display("FAIL basic_latency: got %0d expected 33", lat); end
    nCmp++; if (bus.oData !== 64'hF) begin nFail++; $display("FAIL basic_data: got %h expected %h", bus.oData, 64'hF); end
    @(posedge iClk); @(negedge iClk);
    nCmp++; if (bus.oBusy !== 1'b0) begin nFail++; $display("FAIL basic_busy_after: got %b expected 0", bus.oBusy); end
    nCmp++; if (bus.oValid !== 1'b0) begin nFail++; $display("FAIL basic_strobe_len: got %b expected 0", bus.oValid); end
    nCmp++; if (bus.oData !== 64'hF) begin nFail++; $display("FAIL basic_hold: got %h expected %h", bus.oData, 64'hF); end
  endtask

  task automatic test_extremes;
    logic [31:0] ta [4] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
    logic [31:0] tb [4] = '{32'd5, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
    logic        ts [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    logic [63:0] te [4] = '{64'hFFFFFFFFFFFFFFF1, 64'hFFFFFFFE00000001, 64'h4000000000000000, 64'hC000000080000000};
    logic [31:0] a, b;
    logic        s;
    int lat;
    for (int i = 0; i < 4; i++) begin
      startOp(0, ta[i], tb[i], ts[i]);
      waitValid(0, lat);
      nCmp++; if (lat !== 33) begin nFail++; $display("FAIL extreme_latency[%0d]: got %0d expected 33", i, lat); end
      nCmp++; if (bus.oData !== te[i]) begin nFail++; $display("FAIL extreme_data[%0d]: got %h expected %h", i, bus.oData, te[i]); end
    end
    for (int i = 0; i < 12; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = (i % 2 == 0) ? 32'h80000000 : 32'h0;
      startOp(0, a, b, s);
      waitValid(0, lat);
      nCmp++; if (bus.oData !== refMul(a, b, s)) begin nFail++; $display("FAIL rand_data: %h*%h s=%b got %h expected %h", a, b, s, bus.oData, refMul(a, b, s)); end
    end
  endtask

  task automatic test_stall;
    logic [31:0] a, b;
    int lat, nv, nb;
    a = $urandom; b = $urandom | 32'd1;
    startOp(0, a, b, 1'b1);
    repeat (5) begin @(posedge iClk); @(negedge iClk); end
    iEn = 1'b0;
    bus.iData0 = ~a; bus.iData1 = 32'd3; bus.iStart = 1'b1;
    repeat (4) begin @(posedge iClk); @(negedge iClk); end
    iEn = 1'b1; bus.iStart = 1'b0;
    waitValid(0, lat);
    if (lat > 0) lat = lat + 9;
    nCmp++; if (lat !== 37) begin nFail++; $display("FAIL stall_latency: got %0d expected 37", lat); end
    nCmp++; if (bus.oData !== refMul(a, b, 1'b1)) begin nFail++; $display("FAIL stall_data: got %h expected %h", bus.oData, refMul(a, b, 1'b1)); end
    watch(0, 50, nv, nb);
    nCmp++; if (nv !== 0 || nb !== 0) begin nFail++; $display("FAIL stall_no_second_op: got valid=%0d busy=%0d expected 0/0", nv, nb); end
  endtask

  task automatic test_clear;
    int nv, nb, lat;
    startOp(0, $urandom | 32'd1, $urandom | 32'd1, 1'b0);
    repeat (10) begin @(posedge iClk); @(negedge iClk); end
    iClr = 1'b1; bus.iStart = 1'b1;
    @(posedge iClk); @(negedge iClk);
    iClr = 1'b0; bus.iStart = 1'b0;
    nCmp++; if (bus.oData !== 64'd0) begin nFail++; $display("FAIL clear_data: got %h expected 0", bus.oData); end
    nCmp++; if (bus.oBusy !== 1'b0) begin nFail++; $display("FAIL clear_busy: got %b expected 0", bus.oBusy); end
    watch(0, 50, nv, nb);
    nCmp++; if (nv !== 0 || nb !== 0) begin nFail++; $display("FAIL clear_quiet: got valid=%0d busy=%0d expected 0/0", nv, nb); end
    // Asynchronous reset between edges.
    startOp(0, 32'd7, 32'd11, 1'b0);
    waitValid(0, lat);
    nCmp++; if (bus.oData !== 64'd77) begin nFail++; $display("FAIL prereset_data: got %h expected %h", bus.oData, 64'd77); end
    startOp(0, 32'd9, 32'd9, 1'b0);
    repeat (5) begin @(posedge iClk); @(negedge iClk); end
    #2 iRst = 1'b1;
    #1;
    nCmp++; if (bus.oData !== 64'd0) begin nFail++; $display("FAIL async_reset_data: got %h expected 0", bus.oData); end
    nCmp++; if (bus.oBusy !== 1'b0) begin nFail++; $display("FAIL async_reset_busy: got %b expected 0", bus.oBusy); end
    @(negedge iClk);
    iRst = 1'b0;
    watch(0, 50, nv, nb);
    nCmp++; if (nv !== 0 || nb !== 0) begin nFail++; $display("FAIL reset_quiet: got valid=%0d busy=%0d expected 0/0", nv, nb); end
  endtask

  task automatic test_back_to_back;
    logic [31:0] a, b;
    logic        s;
    int lat;
    startOp(1, 32'd7, 32'd9, 1'b0);
    waitValid(1, lat);
    nCmp++; if (lat !== 9) begin nFail++; $display("FAIL bpc4_latency: got %0d expected 9", lat); end
    nCmp++; if (bus4.oData !== 64'd63) begin nFail++; $display("FAIL bpc4_data: got %h expected %h", bus4.oData, 64'd63); end
    for (int i = 0; i < 6; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      if (i == 0) begin a = 32'h80000000; b = 32'h80000000; s = 1'b1; end
      startOp(1, a, b, s);
      waitValid(1, lat);
      nCmp++; if (lat + 1 !== 10) begin nFail++; $display("FAIL b2b_spacing[%0d]: got %0d expected 10", i, lat + 1); end
      nCmp++; if (getData(1) !== refMul(a, b, s)) begin nFail++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, getData(1), refMul(a, b, s)); end
    end
  endtask

`ifdef MULTIPLIER_ITER_PP_ACC_EN
  task automatic test_acc;
    logic [31:0] a, b;
    logic        s;
    logic [63:0] total;
    int lat;
    @(posedge iClk); @(negedge iClk);
    bus.iAcc = 1'b0;
    startOp(0, 32'd2, 32'd3, 1'b0);
    waitValid(0, lat);
    nCmp++; if (bus.oData !== 64'd6) begin nFail++; $display("FAIL acc_first: got %h expected 6", bus.oData); end
    bus.iAcc = 1'b1;
    startOp(0, 32'd4, 32'd5, 1'b0);
    waitValid(0, lat);
    nCmp++; if (bus.oData !== 64'd26) begin nFail++; $display("FAIL acc_second: got %h expected 26", bus.oData); end
    total = 64'd26;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      total = total + refMul(a, b, s);
      startOp(0, a, b, s);
      waitValid(0, lat);
      nCmp++; if (bus.oData !== total) begin nFail++; $display("FAIL acc_rand[%0d]: got %h expected %h", i, bus.oData, total); end
    end
    iClr = 1'b1;
    @(posedge iClk); @(negedge iClk);
    iClr = 1'b0;
    nCmp++; if (bus.oData !== 64'd0) begin nFail++; $display("FAIL acc_clear: got %h expected 0", bus.oData); end
    bus.iAcc = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_extremes();
    test_stall();
    test_clear();
    test_back_to_back();
`ifdef MULTIPLIER_ITER_PP_ACC_EN
    test_acc();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end
endmodule
